io_uart_tx: RTL
===============

# io_uart_tx

Serial transmitter on the consuming side of the CPU's I/O write port. Each byte the CPU writes (`io_write` with `io_data_out`) is captured into a small FIFO. The bytes are shifted out on a single line as 8N1 UART frames, LSB first. The block sits in `cpu_top` beside the I/O output register, driven by the same CPU signals.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal values are 2 or more.
- `FIFO_DEPTH`, 4: FIFO entries; legal values are powers of two from 2 to 16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_data_in`  in  8  byte from the CPU (`cpu_io_output`).
- `io_write`  in  1  single-cycle write strobe from the CPU; one byte per high cycle.
- `tx`  out  1  serial line; idles high.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes (registered count).
- `busy`  out  1  high when the FIFO is non-empty or a frame is in progress.
- `overflow`  out  1  sticky; set when a write is dropped, cleared only by `reset`.

## Operation
- FIFO: circular buffer with read pointer, write pointer and a count of width clog2(`FIFO_DEPTH`)+1. Pointers wrap modulo `FIFO_DEPTH`.
- Write: on `io_write`=1 with registered `fifo_full`=0, the byte is stored and the count increments.
- Dropped write: `io_write`=1 while `fifo_full`=1 discards the byte and sets `overflow`. This applies even if a pop occurs in the same cycle, because fullness is judged on the registered count.
- Pop: occurs only in IDLE with registered count > 0. The head byte is loaded into the shift register and the read pointer advances.
- Simultaneous write and pop: the count is unchanged and both pointers advance.
- FSM states and transitions:
  - IDLE: `tx`=1. If count > 0, pop and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx` = shift[0]. After each `CLKS_PER_BIT` cycles, shift right and increment the bit index (0..7). After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then pop and go to START if count > 0, else go to IDLE.
- Baud counter: runs 0..`CLKS_PER_BIT`-1 and reloads to 0 on every state or bit change. It is held at 0 in IDLE.
- `tx` is a registered output.
- `busy` = (state != IDLE) | (count != 0).
- Reset values: `tx`=1, `fifo_full`=0, `busy`=0, `overflow`=0. FSM in IDLE, pointers and count at 0, baud counter and bit index at 0.
- Reset mid-frame: on the reset edge the frame is abandoned, `tx` returns to 1, and all queued bytes are lost.

## Timing
- Latency: `io_write` high in cycle 0 with the FIFO empty and the FSM in IDLE:
  - byte is in the FIFO at cycle 1;
  - pop occurs in cycle 1;
  - `tx` is low from cycle 2.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles, measured from the first low cycle of the start bit to the end of the stop bit.
- Back-to-back frames: when the FIFO is non-empty at the end of a stop bit, the next start bit begins on the very next cycle. There is no extra idle cycle.
- `fifo_full` and `busy` update one cycle after the causing write or pop.
- `overflow` goes high the cycle after the dropped write.
- No handshake back to the CPU. Software must poll or pace its writes; dropped bytes are flagged only by `overflow`.

## Test plan
- Reset and idle (`CLKS_PER_BIT`=4): assert `reset` for 2 cycles → `tx`=1, `busy`=0, `fifo_full`=0 and `overflow`=0, and these stay unchanged for 100 idle cycles.
- Single byte (`CLKS_PER_BIT`=4): write 0xA5 in cycle 0 → `tx` low in cycles 2–5. Data bits follow as 1,0,1,0,0,1,0,1, each held for 4 cycles. Stop bit is high in cycles 38–41. `busy` falls in cycle 42.
- Back-to-back: write 0x00, 0xFF and 0x55 on three consecutive cycles → three contiguous frames of 40 cycles each with no idle gap. The decoded bytes are 0x00, 0xFF, 0x55 in order.
- Full and overflow (`FIFO_DEPTH`=4): write 6 bytes on consecutive cycles starting from idle. The first byte is popped at once, so bytes 2–5 fill the FIFO and `fifo_full` rises. Byte 6 is dropped and `overflow`=1. Exactly five frames are transmitted.
- Wrap-around: run 20 or more single writes, paced so the FIFO never fills → the pointers wrap at least 4 times, every byte is received intact, and `overflow` stays 0.
- Reset mid-frame: assert `reset` during data bit 3 of a frame with 2 further bytes queued → `tx`=1 the cycle after reset. `busy`=0 and no further frames are sent. A new write then produces a normal frame with the specified latency.

Source files
------------

// File: rtl/io_uart_tx_if.sv
// ----------------------------------------------------------------------------
// io_uart_tx_if
//
// Purpose:
//    Bundles the CPU-facing write port and the status/serial outputs of the
//    UART transmitter so the block drops into cpu_top as a single connection.
//
// Signals:
//    io_data_in  [7:0]  byte presented by the CPU (cpu_io_output)
//    io_write           single-cycle write strobe, one byte per high cycle
//    tx                 serial line, idles high
//    fifo_full          FIFO holds FIFO_DEPTH bytes
//    busy               FIFO non-empty or a frame in progress
//    overflow           sticky flag, a write was dropped
//
// Modports:
//    master  CPU side (drives data/strobe, observes status)
//    slave   transmitter side
// ----------------------------------------------------------------------------
interface io_uart_tx_if;

   logic [7:0] io_data_in;
   logic       io_write;
   logic       tx;
   logic       fifo_full;
   logic       busy;
   logic       overflow;

   modport master (
      output io_data_in,
      output io_write,
      input  tx,
      input  fifo_full,
      input  busy,
      input  overflow
   );

   modport slave (
      input  io_data_in,
      input  io_write,
      output tx,
      output fifo_full,
      output busy,
      output overflow
   );

endinterface

// File: rtl/io_uart_tx.sv
// ----------------------------------------------------------------------------
// io_uart_tx
//
// Purpose:
//    Serial transmitter on the consuming side of the CPU I/O write port.
//    Every byte strobed in with io_write is queued in a small circular FIFO
//    and shifted out as an 8N1 UART frame, LSB first. Frames are sent
//    back-to-back while the FIFO has data.
//
// Parameters:
//    CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//    FIFO_DEPTH    FIFO entries (power of two, 2..16)
//
// Ports:
//    clk    system clock, all state updates on the rising edge
//    reset  synchronous active-high reset
//    bus    io_uart_tx_if.slave
//              io_data_in/io_write in, tx/fifo_full/busy/overflow out
// ----------------------------------------------------------------------------
module io_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic         clk,
   input  logic         reset,
   io_uart_tx_if.slave  bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   // Transmit FSM state and datapath registers
   state_t         r_state;
   state_t         w_stateNext;
   logic [BW-1:0]  r_baudCnt;
   logic [BW-1:0]  w_baudNext;
   logic [2:0]     r_bitIdx;
   logic [2:0]     w_bitIdxNext;
   logic [7:0]     r_shift;
   logic [7:0]     w_shiftNext;
   logic           r_tx;
   logic           w_txNext;

   // FIFO storage and bookkeeping
   logic [7:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]  r_rdPtr;
   logic [PW-1:0]  r_wrPtr;
   logic [CW-1:0]  r_count;
   logic           r_overflow;

   logic           w_full;
   logic           w_notEmpty;
   logic           w_doWrite;
   logic           w_dropWrite;
   logic           w_doPop;
   logic           w_baudDone;

   // Fullness is judged on the registered count only, so a pop in the same
   // cycle never rescues a write that arrives while the FIFO reads full.
   assign w_full      = (r_count == CW'(FIFO_DEPTH));
   assign w_notEmpty  = (r_count != '0);
   assign w_doWrite   = bus.io_write & ~w_full;
   assign w_dropWrite = bus.io_write &  w_full;
   assign w_baudDone  = (r_baudCnt == BW'(CLKS_PER_BIT - 1));

   // Next-state logic for the transmit FSM. A pop happens only when the FSM
   // is ready for a new byte: directly from IDLE, or at the end of a stop bit
   // so consecutive frames follow each other without an idle cycle.
   always_comb begin
      w_stateNext  = r_state;
      w_baudNext   = r_baudCnt;
      w_bitIdxNext = r_bitIdx;
      w_shiftNext  = r_shift;
      w_doPop      = 1'b0;

      unique case (r_state)
         IDLE: begin
            w_baudNext = '0;
            if (w_notEmpty) begin
               w_doPop      = 1'b1;
               w_shiftNext  = r_mem[r_rdPtr];
               w_stateNext  = START;
            end
         end

         START: begin
            if (w_baudDone) begin
               w_baudNext   = '0;
               w_bitIdxNext = '0;
               w_stateNext  = DATA;
            end else begin
               w_baudNext   = r_baudCnt + BW'(1);
            end
         end

         DATA: begin
            if (w_baudDone) begin
               w_baudNext = '0;
               if (r_bitIdx == 3'd7) begin
                  w_stateNext  = STOP;
               end else begin
                  w_shiftNext  = {1'b0, r_shift[7:1]};
                  w_bitIdxNext = r_bitIdx + 3'd1;
               end
            end else begin
               w_baudNext = r_baudCnt + BW'(1);
            end
         end

         STOP: begin
            if (w_baudDone) begin
               w_baudNext = '0;
               if (w_notEmpty) begin
                  w_doPop     = 1'b1;
                  w_shiftNext = r_mem[r_rdPtr];
                  w_stateNext = START;
               end else begin
                  w_stateNext = IDLE;
               end
            end else begin
               w_baudNext = r_baudCnt + BW'(1);
            end
         end
      endcase
   end

   // The line level is derived from the upcoming state so that the registered
   // tx changes on the same edge as the state, giving the start bit one cycle
   // after the pop with no extra pipeline delay.
   always_comb begin
      w_txNext = 1'b1;
      unique case (w_stateNext)
         START:   w_txNext = 1'b0;
         DATA:    w_txNext = w_shiftNext[0];
         default: w_txNext = 1'b1;
      endcase
   end

   // FSM and shift-path registers. Reset abandons any frame in flight and
   // returns the line to the idle-high level immediately.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_baudCnt <= '0;
         r_bitIdx  <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
      end else begin
         r_state   <= w_stateNext;
         r_baudCnt <= w_baudNext;
         r_bitIdx  <= w_bitIdxNext;
         r_shift   <= w_shiftNext;
         r_tx      <= w_txNext;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag. A simultaneous
   // write and pop moves both pointers but leaves the count unchanged.
   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdPtr    <= '0;
         r_wrPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_doWrite) begin
            r_wrPtr <= r_wrPtr + PW'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PW'(1);
         end
         if (w_doWrite && !w_doPop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_doWrite && w_doPop) begin
            r_count <= r_count - CW'(1);
         end
         if (w_dropWrite) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // FIFO storage needs no reset: an entry is only ever read after it has
   // been written, and the count guards every read.
   always_ff @(posedge clk) begin
      if (w_doWrite) begin
         r_mem[r_wrPtr] <= bus.io_data_in;
      end
   end

   assign bus.tx        = r_tx;
   assign bus.fifo_full = w_full;
   assign bus.busy      = (r_state != IDLE) | w_notEmpty;
   assign bus.overflow  = r_overflow;

endmodule
